// File: rtl/ecap5_dproc_pkg.sv
// ecap5_dproc_pkg: shared bus widths and wishbone slave state encoding
package ecap5_dproc_pkg;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;
    typedef enum logic [1:0] {IDLE, WAIT, ACK} wb_slv_state_t;
endpackage

// File: rtl/wb_mem_array.sv
// wb_mem_array: byte-enable RAM with synchronous write and combinational read
module wb_mem_array
    import ecap5_dproc_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [WB_SEL_W-1:0] sel_i,
    input  logic [AW-1:0]       addr_i,
    input  logic [WB_DAT_W-1:0] dat_i,
    output logic [WB_DAT_W-1:0] dat_o
);
    logic [WB_DAT_W-1:0] mem_q [1<<AW];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < WB_SEL_W; i++) begin
                if (sel_i[i]) mem_q[addr_i][8*i +: 8] <= dat_i[8*i +: 8];
            end
        end
    end

    assign dat_o = mem_q[addr_i];
endmodule

// File: rtl/wb_mem_slave.sv
// wb_mem_slave: wishbone classic responder over a byte-writable word memory
// with a configurable number of wait states before each ack.
module wb_mem_slave
    import ecap5_dproc_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [31:0]         wb_adr_i,
    input  logic [WB_DAT_W-1:0] wb_dat_i,
    output logic [WB_DAT_W-1:0] wb_dat_o,
    input  logic                wb_we_i,
    input  logic [WB_SEL_W-1:0] wb_sel_i,
    input  logic                wb_stb_i,
    input  logic                wb_cyc_i,
    output logic                wb_ack_o
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    wb_slv_state_t       state_q;
    logic [3:0]          cnt_q;
    logic [AW-1:0]       adr_q;
    logic                we_q;
    logic [WB_SEL_W-1:0] sel_q;
    logic [WB_DAT_W-1:0] wdat_q;
    logic [WB_DAT_W-1:0] rdat_q;
    logic                ack_q;

    logic                capture;
    logic                go_ack;
    logic                in_idle;
    logic                mem_we;
    logic [AW-1:0]       mem_adr;
    logic [WB_SEL_W-1:0] mem_sel;
    logic [WB_DAT_W-1:0] mem_wdat;
    logic [WB_DAT_W-1:0] mem_rdat;
    logic                unused_adr;

    assign unused_adr = ^{wb_adr_i[31:AW+2], wb_adr_i[1:0]};

    // With zero wait states the capture edge is also the ACK-entry edge,
    // so the memory port is fed straight from the bus instead of the latches.
    always_comb begin
        in_idle  = state_q == IDLE;
        capture  = in_idle && wb_cyc_i && wb_stb_i;
        go_ack   = (capture && WAIT_STATES == 0) || (state_q == WAIT && wb_cyc_i && cnt_q == '0);
        mem_adr  = in_idle ? wb_adr_i[AW+1:2] : adr_q;
        mem_sel  = in_idle ? wb_sel_i : sel_q;
        mem_wdat = in_idle ? wb_dat_i : wdat_q;
        mem_we   = rst_n_i && go_ack && (in_idle ? wb_we_i : we_q);
    end

    wb_mem_array #(.AW(AW)) u_mem (
        .clk_i (clk_i),
        .we_i  (mem_we),
        .sel_i (mem_sel),
        .addr_i(mem_adr),
        .dat_i (mem_wdat),
        .dat_o (mem_rdat)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            ack_q  <= go_ack;
            rdat_q <= go_ack ? mem_rdat : '0;
            case (state_q)
                IDLE: if (capture) begin
                    adr_q   <= wb_adr_i[AW+1:2];
                    we_q    <= wb_we_i;
                    sel_q   <= wb_sel_i;
                    wdat_q  <= wb_dat_i;
                    cnt_q   <= WS_LOAD;
                    state_q <= (WAIT_STATES == 0) ? ACK : WAIT;
                end
                WAIT: if (!wb_cyc_i) begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end else if (cnt_q == '0) begin
                    state_q <= ACK;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wb_dat_o = rdat_q;
    assign wb_ack_o = ack_q;
endmodule
